// File: rtl/blinkled_pio_out_if.sv
// Avalon-MM slave bus for the blinking LED PIO.
// Writes complete on the edge where chipselect && !write_n; readdata is registered (1-cycle latency).
interface blinkled_pio_out_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/blinkled_pio_out.sv
// Avalon-MM output PIO for board LEDs with per-bit hardware blinking
// driven by a programmable half-period counter and a wrap interrupt.
module blinkled_pio_out #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned PERIOD_W     = 24,
  parameter logic [31:0] RESET_PERIOD = 32'd4999999,
  parameter logic [31:0] RESET_DATA   = 32'd0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  blinkled_pio_out_if.slave    bus,
  output logic [WIDTH-1:0]     out_port,
  output logic                 irq
);
  localparam logic [2:0] A_DATA     = 3'd0;
  localparam logic [2:0] A_BLINK    = 3'd1;
  localparam logic [2:0] A_PERIOD   = 3'd2;
  localparam logic [2:0] A_CONTROL  = 3'd3;
  localparam logic [2:0] A_STATUS   = 3'd4;
  localparam logic [2:0] A_OUTSET   = 3'd5;
  localparam logic [2:0] A_OUTCLEAR = 3'd6;
  localparam logic [2:0] A_OUTPUT   = 3'd7;

  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    blink_en;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] counter;
  logic                run;
  logic                irq_en;
  logic                wrap_flag;
  logic                phase;

  logic                wr;
  logic [WIDTH-1:0]    wd;
  logic                period_wr;
  logic                run_clear;
  logic                active;
  logic                wrap;
  logic [31:0]         rd_mux;
  logic                unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign wd           = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^{bus.writedata, 1'b0};
  assign period_wr    = wr && (bus.address == A_PERIOD);
  // Clearing run in the same cycle as a wrap must suppress the wrap entirely.
  assign run_clear    = wr && (bus.address == A_CONTROL) && !bus.writedata[0];
  assign active       = run && !run_clear;
  assign wrap         = active && !period_wr && (counter >= period);
  assign irq          = wrap_flag & irq_en;

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      A_DATA:    rd_mux[WIDTH-1:0]    = data;
      A_BLINK:   rd_mux[WIDTH-1:0]    = blink_en;
      A_PERIOD:  rd_mux[PERIOD_W-1:0] = period;
      A_CONTROL: rd_mux[1:0]          = {irq_en, run};
      A_STATUS:  rd_mux[1:0]          = {phase, wrap_flag};
      A_OUTPUT:  rd_mux[WIDTH-1:0]    = out_port;
      default:   rd_mux               = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data         <= RESET_DATA[WIDTH-1:0];
      blink_en     <= '0;
      period       <= RESET_PERIOD[PERIOD_W-1:0];
      counter      <= '0;
      run          <= 1'b0;
      irq_en       <= 1'b0;
      wrap_flag    <= 1'b0;
      phase        <= 1'b0;
      out_port     <= RESET_DATA[WIDTH-1:0];
      bus.readdata <= '0;
    end else begin
      if (wr) begin
        case (bus.address)
          A_DATA:     data     <= wd;
          A_BLINK:    blink_en <= wd;
          A_PERIOD:   period   <= bus.writedata[PERIOD_W-1:0];
          A_CONTROL: begin
            run    <= bus.writedata[0];
            irq_en <= bus.writedata[1];
          end
          A_OUTSET:   data     <= data | wd;
          A_OUTCLEAR: data     <= data & ~wd;
          default: ;
        endcase
      end

      // >= rather than == so a shrinking PERIOD never lets the counter run away.
      if (!active) begin
        counter <= '0;
        phase   <= 1'b0;
      end else if (period_wr) begin
        counter <= '0;
      end else if (counter >= period) begin
        counter <= '0;
        phase   <= ~phase;
      end else begin
        counter <= counter + PERIOD_W'(1);
      end

      if (wrap)
        wrap_flag <= 1'b1;
      else if (wr && (bus.address == A_STATUS))
        wrap_flag <= 1'b0;

      out_port     <= data ^ (blink_en & {WIDTH{phase}});
      bus.readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_blinkled_pio_out.sv
// Directed bench for blinkled_pio_out: register table plus blink, irq,
// period-rewrite, run/wrap collision and asynchronous reset sequences.
module tb_blinkled_pio_out;
  logic clk;
  logic reset_n;
  logic [7:0] out_port;
  logic irq;
  int checks = 0;
  int errors = 0;

  blinkled_pio_out_if bus ();

  blinkled_pio_out dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port),
    .irq      (irq)
  );

  typedef struct {
    logic        cs;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, let the edge pass, return 1 ns after it.
  task automatic cycle(input logic cs, input logic we, input logic [2:0] a, input logic [31:0] d);
    bus.chipselect = cs;
    bus.write_n    = ~we;
    bus.address    = a;
    bus.writedata  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    cycle(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 3'd0, 32'h0);
  endtask

  task automatic add(input logic cs, input logic we, input logic [2:0] a, input logic [31:0] d,
                     input logic chk_rd, input logic [31:0] exp_rd, input logic [7:0] exp_out);
    vec_t v;
    v.cs = cs; v.we = we; v.addr = a; v.wdata = d;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_out = exp_out;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] exp_o;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 32'h0;
    reset_n        = 1'b0;

    // Register vectors: out_port/readdata observed after each edge reflect pre-edge state
    add(1, 0, 3'd0, 32'h0,        1, 32'h0,     8'h00);
    add(1, 0, 3'd1, 32'h0,        1, 32'h0,     8'h00);
    add(1, 0, 3'd2, 32'h0,        1, 32'd4999999, 8'h00);
    add(1, 0, 3'd3, 32'h0,        1, 32'h0,     8'h00);
    add(1, 0, 3'd4, 32'h0,        1, 32'h0,     8'h00);
    add(1, 0, 3'd5, 32'h0,        1, 32'h0,     8'h00);
    add(1, 0, 3'd6, 32'h0,        1, 32'h0,     8'h00);
    add(1, 0, 3'd7, 32'h0,        1, 32'h0,     8'h00);
    add(1, 1, 3'd0, 32'h0F,       0, 32'h0,     8'h00);
    add(1, 1, 3'd5, 32'h30,       0, 32'h0,     8'h0F);
    add(1, 1, 3'd6, 32'h03,       0, 32'h0,     8'h3F);
    add(1, 0, 3'd7, 32'h0,        0, 32'h0,     8'h3C);
    add(1, 0, 3'd7, 32'h0,        1, 32'h3C,    8'h3C);
    add(1, 0, 3'd0, 32'h0,        1, 32'h3C,    8'h3C);
    add(1, 0, 3'd5, 32'h0,        1, 32'h0,     8'h3C);
    add(1, 1, 3'd0, 32'hABCDFF5A, 0, 32'h0,     8'h3C);
    add(1, 0, 3'd0, 32'h0,        1, 32'h5A,    8'h5A);
    add(1, 1, 3'd1, 32'h00000181, 0, 32'h0,     8'h5A);
    add(1, 0, 3'd1, 32'h0,        1, 32'h81,    8'h5A);
    add(1, 1, 3'd2, 32'hFF000003, 0, 32'h0,     8'h5A);
    add(1, 0, 3'd2, 32'h0,        1, 32'h3,     8'h5A);
    add(1, 1, 3'd3, 32'hFFFFFFFC, 0, 32'h0,     8'h5A);
    add(1, 0, 3'd3, 32'h0,        1, 32'h0,     8'h5A);
    add(1, 1, 3'd0, 32'h01,       0, 32'h0,     8'h5A);
    add(1, 0, 3'd0, 32'h0,        1, 32'h01,    8'h01);
    add(1, 1, 3'd7, 32'hFF,       0, 32'h0,     8'h01);
    add(1, 0, 3'd0, 32'h0,        1, 32'h01,    8'h01);
    add(0, 0, 3'd0, 32'h0,        0, 32'h0,     8'h01);

    repeat (3) @(posedge clk);
    #1;
    check("reset out_port", 32'(out_port), 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    check("reset readdata", bus.readdata, 32'h0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].cs, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d out_port", i), 32'(out_port), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d irq", i), 32'(irq), 32'h0);
      if (vecs[i].chk_rd)
        check($sformatf("vec%0d readdata", i), bus.readdata, vecs[i].exp_rd);
    end

    // Blink: PERIOD=3, BLINK_EN=0x81, DATA=0x01, run set at E0
    wr(3'd3, 32'h1);
    check("blink start out", 32'(out_port), 32'h01);
    for (int k = 1; k <= 16; k++) begin
      idle();
      exp_o = ((((k - 1) / 4) % 2) != 0) ? 8'h80 : 8'h01;
      check($sformatf("blink out k=%0d", k), 32'(out_port), 32'(exp_o));
    end
    rd(3'd4);
    check("blink status", bus.readdata, 32'h1);

    // IRQ: rises on wrap, clears after STATUS write, stays set if cleared on wrap edge
    wr(3'd3, 32'h0);
    wr(3'd4, 32'h0);
    check("irq cleared", 32'(irq), 32'h0);
    wr(3'd3, 32'h3);
    check("irq after enable", 32'(irq), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      idle();
      check($sformatf("irq pre-wrap k=%0d", k), 32'(irq), 32'h0);
    end
    idle();
    check("irq at wrap", 32'(irq), 32'h1);
    wr(3'd4, 32'h0);
    check("irq after clear", 32'(irq), 32'h0);
    idle();
    idle();
    check("irq before 2nd wrap", 32'(irq), 32'h0);
    wr(3'd4, 32'h0);
    check("irq set beats clear", 32'(irq), 32'h1);
    rd(3'd3);
    check("control readback", bus.readdata, 32'h3);

    // PERIOD rewrite at counter=7 restarts the count
    wr(3'd3, 32'h0);
    wr(3'd2, 32'd9);
    wr(3'd3, 32'h1);
    repeat (7) idle();
    wr(3'd2, 32'd2);
    check("rewrite out", 32'(out_port), 32'h01);
    for (int k = 1; k <= 3; k++) begin
      idle();
      check($sformatf("rewrite hold k=%0d", k), 32'(out_port), 32'h01);
    end
    idle();
    check("rewrite toggle", 32'(out_port), 32'h80);
    wr(3'd3, 32'h0);
    rd(3'd4);
    check("stop status", bus.readdata, 32'h1);
    check("stop out", 32'(out_port), 32'h01);

    // Clearing run on the wrap edge: no toggle, no flag
    wr(3'd2, 32'd3);
    wr(3'd4, 32'h0);
    wr(3'd3, 32'h1);
    repeat (3) idle();
    wr(3'd3, 32'h0);
    rd(3'd4);
    check("run clear on wrap status", bus.readdata, 32'h0);
    check("run clear on wrap out", 32'(out_port), 32'h01);

    // Asynchronous reset mid-run with PERIOD=0
    wr(3'd2, 32'd0);
    wr(3'd3, 32'h3);
    idle();
    idle();
    rd(3'd7);
    rd(3'd7);
    check("pre-reset irq", 32'(irq), 32'h1);
    check("pre-reset readdata nonzero", 32'(bus.readdata != 32'h0), 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async reset out_port", 32'(out_port), 32'h0);
    check("async reset irq", 32'(irq), 32'h0);
    check("async reset readdata", bus.readdata, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd(3'd2);
    check("post-reset period", bus.readdata, 32'd4999999);
    rd(3'd3);
    check("post-reset control", bus.readdata, 32'h0);
    rd(3'd4);
    check("post-reset status", bus.readdata, 32'h0);
    check("post-reset out", 32'(out_port), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
